// File: rtl/conv_3x3_layer_sequencer.sv
// rtl/conv_3x3_layer_sequencer.sv - per-output-channel weight load, pixel gating and result counting for one 3x3 conv layer
module conv_3x3_layer_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int CHANNEL_NUM_IN  = 128,
  parameter int CHANNEL_NUM_OUT = 128,
  parameter int KERNEL          = 3,
  parameter int W_ADDR_WIDTH    = 18,
  parameter int PASS_PXL_NUM    = 2097152,
  parameter int OUT_PXL_NUM     = 16384
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stride2_cfg,
  output logic                    busy,
  output logic                    done,
  output logic [((CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1)-1:0] oc_idx,
  output logic                    stride2,
  output logic                    w_rd_en,
  output logic [W_ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0]   w_rd_data,
  output logic                    valid_weight_out,
  output logic [DATA_WIDTH-1:0]   weight_out,
  output logic                    pxl_ready,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   pxl_in,
  output logic                    valid_pxl_out,
  output logic [DATA_WIDTH-1:0]   pxl_out,
  input  logic                    res_valid,
  output logic                    err
);

  localparam int W_PER_OC = KERNEL * KERNEL * CHANNEL_NUM_IN;
  localparam int OC_W     = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int K_W      = $clog2(W_PER_OC + 1);
  localparam int IN_W     = $clog2(PASS_PXL_NUM + 1);
  localparam int RES_W    = $clog2(OUT_PXL_NUM + 1);

  localparam logic [K_W-1:0]          K_END    = K_W'(W_PER_OC);
  localparam logic [IN_W-1:0]         IN_LAST  = IN_W'(PASS_PXL_NUM - 1);
  localparam logic [RES_W-1:0]        RES_END  = RES_W'(OUT_PXL_NUM);
  localparam logic [RES_W-1:0]        RES_LAST = RES_W'(OUT_PXL_NUM - 1);
  localparam logic [OC_W-1:0]         OC_LAST  = OC_W'(CHANNEL_NUM_OUT - 1);
  localparam logic [W_ADDR_WIDTH-1:0] W_STEP   = W_ADDR_WIDTH'(W_PER_OC);

  typedef enum logic [2:0] {IDLE, LOAD_W, W_FLUSH, STREAM, DRAIN, DONE} state_t;

  state_t                  state;
  logic [K_W-1:0]          k;
  logic [W_ADDR_WIDTH-1:0] base;
  logic [IN_W-1:0]         in_cnt;
  logic [RES_W-1:0]        res_cnt;

  logic res_window;
  logic res_full;
  logic chan_done;
  logic accept;

  assign res_window = (state == STREAM) || (state == DRAIN);
  assign res_full   = (res_cnt == RES_END);
  assign chan_done  = res_full || (res_valid && (res_cnt == RES_LAST));
  assign accept     = pxl_ready && valid_in;

  // ROM data arrives in the same cycle the delayed strobe is high
  assign weight_out = valid_weight_out ? w_rd_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      oc_idx           <= '0;
      stride2          <= 1'b0;
      w_rd_en          <= 1'b0;
      w_addr           <= '0;
      valid_weight_out <= 1'b0;
      pxl_ready        <= 1'b0;
      valid_pxl_out    <= 1'b0;
      pxl_out          <= '0;
      err              <= 1'b0;
      k                <= '0;
      base             <= '0;
      in_cnt           <= '0;
      res_cnt          <= '0;
    end else begin
      valid_weight_out <= w_rd_en;
      valid_pxl_out    <= accept;
      done             <= 1'b0;
      if (accept) pxl_out <= pxl_in;

      // Overrun is flagged instead of counted so the counter never wraps
      if (res_valid) begin
        if (!res_window || res_full) err <= 1'b1;
        else res_cnt <= res_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            stride2 <= stride2_cfg;
            oc_idx  <= '0;
            base    <= '0;
            w_addr  <= '0;
            k       <= K_W'(1);
            w_rd_en <= 1'b1;
            busy    <= 1'b1;
            state   <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (k == K_END) begin
            w_rd_en <= 1'b0;
            w_addr  <= '0;
            state   <= W_FLUSH;
          end else begin
            w_addr <= base + W_ADDR_WIDTH'(k);
            k      <= k + 1'b1;
          end
        end
        W_FLUSH: begin
          pxl_ready <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (valid_in) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == IN_LAST) begin
              pxl_ready <= 1'b0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (chan_done) begin
            in_cnt  <= '0;
            res_cnt <= '0;
            if (oc_idx == OC_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              oc_idx  <= oc_idx + 1'b1;
              base    <= base + W_STEP;
              w_addr  <= base + W_STEP;
              k       <= K_W'(1);
              w_rd_en <= 1'b1;
              state   <= LOAD_W;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_3x3_layer_sequencer.sv
// tb/tb_conv_3x3_layer_sequencer.sv - randomized scenario bench for conv_3x3_layer_sequencer
module tb_conv_3x3_layer_sequencer;

  localparam int DW   = 16;
  localparam int CIN  = 2;
  localparam int COUT = 2;
  localparam int PASS = 8;
  localparam int OUTN = 4;
  localparam int WPO  = 9 * CIN;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          reset, start, stride2_cfg;
  logic          busy, done, stride2, w_rd_en;
  logic [0:0]    oc_idx;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_rd_data, weight_out, pxl_in, pxl_out;
  logic          valid_weight_out, pxl_ready, valid_in, valid_pxl_out, res_valid, err;

  logic [DW-1:0] rom [0:WPO*COUT-1];
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit exp_err = 1'b0;

  conv_3x3_layer_sequencer #(
    .DATA_WIDTH(DW), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT), .KERNEL(3),
    .W_ADDR_WIDTH(AW), .PASS_PXL_NUM(PASS), .OUT_PXL_NUM(OUTN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stride2_cfg(stride2_cfg),
    .busy(busy), .done(done), .oc_idx(oc_idx), .stride2(stride2),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .valid_weight_out(valid_weight_out), .weight_out(weight_out),
    .pxl_ready(pxl_ready), .valid_in(valid_in), .pxl_in(pxl_in),
    .valid_pxl_out(valid_pxl_out), .pxl_out(pxl_out),
    .res_valid(res_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous-read weight ROM
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= (int'(w_addr) < WPO*COUT) ? rom[w_addr] : 16'hdead;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    tests++; if ({busy, done, oc_idx, stride2, err} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got=%b exp=0", {busy, done, oc_idx, stride2, err}); end
    tests++; if ({w_rd_en, w_addr, valid_weight_out, weight_out} !== '0) begin fails++; $display("FAIL reset_weight got=%h exp=0", {w_rd_en, w_addr, valid_weight_out, weight_out}); end
    tests++; if ({pxl_ready, valid_pxl_out, pxl_out} !== '0) begin fails++; $display("FAIL reset_pixel got=%h exp=0", {pxl_ready, valid_pxl_out, pxl_out}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic start_layer(input bit cfg);
    stride2_cfg = cfg;
    start = 1'b1;
    tick();
    start = 1'b0;
    stride2_cfg = ~cfg;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL start_busy got=%b exp=1", busy); end
    tests++; if (stride2 !== cfg) begin fails++; $display("FAIL start_stride2 got=%b exp=%b", stride2, cfg); end
    tests++; if (oc_idx !== 1'b0) begin fails++; $display("FAIL start_oc got=%0d exp=0", oc_idx); end
  endtask

  // Entered on the first LOAD_W cycle; leaves on the first STREAM cycle
  task automatic run_weights(input int oc, input int inject);
    for (int c = 0; c <= WPO; c++) begin
      tests++; if (w_rd_en !== (c < WPO)) begin fails++; $display("FAIL w_rd_en oc=%0d c=%0d got=%b", oc, c, w_rd_en); end
      if (c < WPO) begin
        tests++; if (int'(w_addr) !== oc*WPO + c) begin fails++; $display("FAIL w_addr oc=%0d c=%0d got=%0d exp=%0d", oc, c, w_addr, oc*WPO + c); end
      end
      tests++; if (valid_weight_out !== (c >= 1)) begin fails++; $display("FAIL w_valid oc=%0d c=%0d got=%b", oc, c, valid_weight_out); end
      if (c >= 1) begin
        tests++; if (weight_out !== rom[oc*WPO + c - 1]) begin fails++; $display("FAIL weight oc=%0d c=%0d got=%h exp=%h", oc, c, weight_out, rom[oc*WPO + c - 1]); end
      end
      tests++; if (pxl_ready !== 1'b0 || int'(oc_idx) !== oc) begin fails++; $display("FAIL wload_ctrl c=%0d rdy=%b oc=%0d exp_oc=%0d", c, pxl_ready, oc_idx, oc); end
      tests++; if (err !== exp_err) begin fails++; $display("FAIL err_wload c=%0d got=%b exp=%b", c, err, exp_err); end
      if (c == inject) res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      if (c == inject) exp_err = 1'b1;
    end
    tests++; if (pxl_ready !== 1'b1 || valid_weight_out !== 1'b0) begin fails++; $display("FAIL stream_entry rdy=%b wv=%b exp rdy=1 wv=0", pxl_ready, valid_weight_out); end
  endtask

  task automatic stream(input int bubbles, input bit coincide, input int start_at, input int exp_oc, input bit exp_s2);
    int pre [PASS];
    int cyc;
    logic [DW-1:0] pix;
    cyc = 0;
    foreach (pre[i]) pre[i] = 0;
    for (int b = 0; b < bubbles; b++) pre[$urandom_range(0, PASS-1)]++;
    for (int p = 0; p < PASS; p++) begin
      for (int q = 0; q < pre[p]; q++) begin
        valid_in = 1'b0; pxl_in = DW'($urandom); start = (cyc == start_at);
        tick();
        start = 1'b0; cyc++;
        tests++; if (valid_pxl_out !== 1'b0 || pxl_ready !== 1'b1) begin fails++; $display("FAIL bubble p=%0d vout=%b rdy=%b exp 0/1", p, valid_pxl_out, pxl_ready); end
      end
      pix = DW'($urandom);
      valid_in = 1'b1; pxl_in = pix; res_valid = coincide && (p >= PASS - OUTN); start = (cyc == start_at);
      tick();
      valid_in = 1'b0; res_valid = 1'b0; start = 1'b0; cyc++;
      tests++; if (valid_pxl_out !== 1'b1 || pxl_out !== pix) begin fails++; $display("FAIL pixel p=%0d vout=%b got=%h exp=%h", p, valid_pxl_out, pxl_out, pix); end
      tests++; if (pxl_ready !== (p < PASS - 1)) begin fails++; $display("FAIL pxl_ready p=%0d got=%b exp=%b", p, pxl_ready, p < PASS - 1); end
    end
    tests++; if (int'(oc_idx) !== exp_oc || stride2 !== exp_s2 || busy !== 1'b1) begin fails++; $display("FAIL stream_state oc=%0d s2=%b busy=%b exp oc=%0d s2=%b", oc_idx, stride2, busy, exp_oc, exp_s2); end
    tests++; if (err !== exp_err) begin fails++; $display("FAIL err_stream got=%b exp=%b", err, exp_err); end
    if (coincide) begin
      tests++; if (w_rd_en !== 1'b0) begin fails++; $display("FAIL drain_hold w_rd_en=%b exp=0", w_rd_en); end
      tick();
    end else begin
      valid_in = 1'b1; pxl_in = DW'($urandom);
      tick();
      valid_in = 1'b0;
      tests++; if (valid_pxl_out !== 1'b0) begin fails++; $display("FAIL drain_drop got=%b exp=0", valid_pxl_out); end
    end
  endtask

  task automatic send_results(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      if (i < n - 1) begin
        tests++; if (done !== 1'b0 || w_rd_en !== 1'b0) begin fails++; $display("FAIL early_adv i=%0d done=%b w_rd_en=%b exp 0", i, done, w_rd_en); end
      end
    end
    if (last) begin
      tests++; if (done !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL done_pulse done=%b busy=%b exp 1/1", done, busy); end
      tick();
      tests++; if (done !== 1'b0 || busy !== 1'b0 || int'(oc_idx) !== COUT-1) begin fails++; $display("FAIL layer_end done=%b busy=%b oc=%0d exp 0/0/%0d", done, busy, oc_idx, COUT-1); end
    end
  endtask

  task automatic test_full_layer;
    int d0;
    d0 = done_cnt;
    start_layer(1'b1);
    run_weights(0, -1);
    stream(2, 1'b0, -1, 0, 1'b1);
    send_results(OUTN, 1'b0);
    run_weights(1, -1);
    stream(2, 1'b0, -1, 1, 1'b1);
    send_results(OUTN, 1'b1);
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL done_count got=%0d exp=1", done_cnt - d0); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clean got=%b exp=0", err); end
  endtask

  task automatic test_ignored_start_err;
    start_layer(1'b0);
    run_weights(0, 5);
    stream(3, 1'b0, 4, 0, 1'b0);
    send_results(OUTN, 1'b0);
    run_weights(1, -1);
    stream(1, 1'b0, 2, 1, 1'b0);
    send_results(OUTN, 1'b1);
    repeat (3) tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid;
    int d0;
    reset = 1'b1; tick(); reset = 1'b0; exp_err = 1'b0;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_cleared got=%b exp=0", err); end
    start_layer(1'b1);
    run_weights(0, -1);
    stream(0, 1'b0, -1, 0, 1'b1);
    send_results(2, 1'b0);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    tests++; if ({busy, done, oc_idx, stride2, err, w_rd_en, w_addr, valid_weight_out, weight_out, pxl_ready, valid_pxl_out, pxl_out} !== '0) begin fails++; $display("FAIL abort_outputs busy=%b done=%b oc=%0d s2=%b rdy=%b exp all 0", busy, done, oc_idx, stride2, pxl_ready); end
    reset = 1'b0;
    repeat (4) tick();
    tests++; if (busy !== 1'b0 || done_cnt !== d0) begin fails++; $display("FAIL abort_idle busy=%b dones=%0d exp 0/%0d", busy, done_cnt, d0); end
    start_layer(1'b0);
    run_weights(0, -1);
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic test_coincident;
    start_layer(1'b1);
    run_weights(0, -1);
    stream(2, 1'b1, -1, 0, 1'b1);
    run_weights(1, -1);
    stream(1, 1'b0, -1, 1, 1'b1);
    send_results(OUTN, 1'b1);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_coincide got=%b exp=0", err); end
  endtask

  initial begin
    foreach (rom[i]) rom[i] = DW'($urandom);
    reset = 1'b1; start = 1'b0; stride2_cfg = 1'b0;
    valid_in = 1'b0; pxl_in = '0; res_valid = 1'b0;
    test_reset();
    test_full_layer();
    test_ignored_start_err();
    test_reset_mid();
    test_coincident();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
